// File: rtl/detect_arbiter.sv
// Four-requester round-robin arbiter feeding one overlapping "1101" Mealy detector per session.
// Optional per-session match counter is built only when DETECT_ARBITER_MATCH_CNT_EN is defined.
module detect_arbiter #(
    parameter int unsigned MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] req,
    input  logic [3:0] w,
    input  logic [3:0] last,
    output logic [3:0] grant,
    output logic       busy,
    output logic       match,
    output logic [1:0] match_id,
    output logic       abort,
    output logic [7:0] match_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        S0   = 2'd0,
        S1   = 2'd1,
        S11  = 2'd2,
        S110 = 2'd3
    } det_t;

    localparam logic [7:0] LAST_IDX = 8'(MAX_LEN - 1);

    state_t     state_q, state_d;
    det_t       det_q, det_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] bitcnt_q, bitcnt_d;
    logic       match_q, match_d;
    logic [1:0] match_id_q, match_id_d;
    logic       abort_q, abort_d;
    logic [1:0] win_s;

    // Round-robin search starting just above the last winner.
    function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] ptr_v);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = ptr_v;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr_v + 2'(k);
            if (!found && req_v[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    function automatic det_t det_step(input det_t s, input logic b);
        det_t n;
        case (s)
            S0:      n = b ? S1  : S0;
            S1:      n = b ? S11 : S0;
            S11:     n = b ? S11 : S110;
            S110:    n = b ? S1  : S0;
            default: n = S0;
        endcase
        return n;
    endfunction

    function automatic logic det_hit(input det_t s, input logic b);
        return (s == S110) && b;
    endfunction

    assign win_s = rr_pick(req, ptr_q);

    // Controller next-state and registered-output next values.
    always_comb begin
        state_d    = state_q;
        det_d      = det_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        bitcnt_d   = bitcnt_q;
        match_d    = 1'b0;
        match_id_d = match_id_q;
        abort_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    grant_d  = 4'b0001 << win_s;
                    ptr_d    = win_s;
                    det_d    = S0;
                    bitcnt_d = 8'd0;
                    state_d  = RUN;
                end else begin
                    grant_d  = 4'b0000;
                    state_d  = IDLE;
                end
            end
            RUN: begin
                if (req[ptr_q]) begin
                    det_d    = det_step(det_q, w[ptr_q]);
                    bitcnt_d = bitcnt_q + 8'd1;
                    if (det_hit(det_q, w[ptr_q])) begin
                        match_d    = 1'b1;
                        match_id_d = ptr_q;
                    end else begin
                        match_d    = 1'b0;
                    end
                    if (last[ptr_q] || (bitcnt_q == LAST_IDX)) begin
                        grant_d = 4'b0000;
                        state_d = GAP;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    // Requester withdrew: its w bit this cycle is not sampled.
                    abort_d = 1'b1;
                    grant_d = 4'b0000;
                    state_d = GAP;
                end
            end
            GAP: begin
                grant_d = 4'b0000;
                state_d = IDLE;
            end
            default: begin
                grant_d = 4'b0000;
                state_d = IDLE;
            end
        endcase
    end

    // Controller and detector state registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q    <= IDLE;
            det_q      <= S0;
            grant_q    <= 4'b0000;
            ptr_q      <= 2'd3;
            bitcnt_q   <= 8'd0;
            match_q    <= 1'b0;
            match_id_q <= 2'd0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            det_q      <= det_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            bitcnt_q   <= bitcnt_d;
            match_q    <= match_d;
            match_id_q <= match_id_d;
            abort_q    <= abort_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = (state_q == RUN);
    assign match    = match_q;
    assign match_id = match_id_q;
    assign abort    = abort_q;

`ifdef DETECT_ARBITER_MATCH_CNT_EN
    logic [7:0] mcnt_q, mcnt_d;

    // Saturating match counter, cleared whenever a new grant is issued.
    always_comb begin
        mcnt_d = mcnt_q;
        if ((state_q == IDLE) && (req != 4'b0000)) begin
            mcnt_d = 8'd0;
        end else if (match_d && (mcnt_q != 8'hFF)) begin
            mcnt_d = mcnt_q + 8'd1;
        end else begin
            mcnt_d = mcnt_q;
        end
    end

    // Match counter register.
    always_ff @(posedge clk) begin
        if (!clr) begin
            mcnt_q <= 8'd0;
        end else begin
            mcnt_q <= mcnt_d;
        end
    end

    assign match_cnt = mcnt_q;
`else
    assign match_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_detect_arbiter.sv
// Directed bench for detect_arbiter (MAX_LEN=8): reset, match, overlap, round-robin, abort, length cap, mid-session reset.
module tb_detect_arbiter;

    logic       clk;
    logic       clr;
    logic [3:0] req;
    logic [3:0] w;
    logic [3:0] last;
    logic [3:0] grant;
    logic       busy;
    logic       match;
    logic [1:0] match_id;
    logic       abort;
    logic [7:0] match_cnt;

    int vecs;
    int errs;

    detect_arbiter #(.MAX_LEN(8)) u_dut (
        .clk       (clk),
        .clr       (clr),
        .req       (req),
        .w         (w),
        .last      (last),
        .grant     (grant),
        .busy      (busy),
        .match     (match),
        .match_id  (match_id),
        .abort     (abort),
        .match_cnt (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DETECT_ARBITER_MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] cnt_exp(input logic [7:0] n);
        return CNT_ON ? n : 8'd0;
    endfunction

    logic [6:0] seq;
    logic [3:0] rr_exp [5];

    initial begin
        vecs = 0;
        errs = 0;
        clr = 1'b0; req = 4'b0000; w = 4'b0000; last = 4'b0000;
        tick(); tick();
        chk("rst_grant", {4'b0, grant}, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_match", {7'b0, match}, 8'h00);
        chk("rst_match_id", {6'b0, match_id}, 8'h00);
        chk("rst_abort", {7'b0, abort}, 8'h00);
        chk("rst_match_cnt", match_cnt, 8'h00);
        clr = 1'b1;
        tick();

        // basic match 1,1,0,1 on requester 0
        req = 4'b0001;
        tick();
        chk("basic_grant0", {4'b0, grant}, 8'h01);
        chk("basic_busy", {7'b0, busy}, 8'h01);
        w = 4'b0001; tick();
        chk("basic_grant1", {4'b0, grant}, 8'h01);
        w = 4'b0001; tick();
        chk("basic_grant2", {4'b0, grant}, 8'h01);
        w = 4'b0000; tick();
        chk("basic_grant3", {4'b0, grant}, 8'h01);
        chk("basic_nomatch3", {7'b0, match}, 8'h00);
        w = 4'b0001; last = 4'b0001; tick();
        chk("basic_grant_end", {4'b0, grant}, 8'h00);
        chk("basic_match", {7'b0, match}, 8'h01);
        chk("basic_match_id", {6'b0, match_id}, 8'h00);
        chk("basic_busy_end", {7'b0, busy}, 8'h00);
        chk("basic_cnt", match_cnt, cnt_exp(8'd1));
        req = 4'b0000; w = 4'b0000; last = 4'b0000;
        tick();
        chk("basic_match_off", {7'b0, match}, 8'h00);
        chk("basic_gap_grant", {4'b0, grant}, 8'h00);
        tick();

        // overlapping pattern 1,1,0,1,1,0,1 on requester 0
        seq = 7'b1011011;
        req = 4'b0001;
        tick();
        chk("ovl_grant", {4'b0, grant}, 8'h01);
        for (int k = 0; k < 7; k++) begin
            w = {3'b000, seq[k]};
            last = (k == 6) ? 4'b0001 : 4'b0000;
            tick();
            chk($sformatf("ovl_match_b%0d", k), {7'b0, match}, ((k == 3) || (k == 6)) ? 8'h01 : 8'h00);
        end
        chk("ovl_cnt", match_cnt, cnt_exp(8'd2));
        req = 4'b0000; w = 4'b0000; last = 4'b0000;
        tick();
        chk("ovl_match_off", {7'b0, match}, 8'h00);
        tick();

        // round-robin from a fresh reset, two-bit sessions
        clr = 1'b0; tick(); clr = 1'b1;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            last = 4'b0000;
            tick();
            chk($sformatf("rr_grant_s%0d", s), {4'b0, grant}, {4'b0, rr_exp[s]});
            tick();
            last = 4'b1111;
            tick();
            chk($sformatf("rr_end_s%0d", s), {4'b0, grant}, 8'h00);
            last = 4'b0000;
            tick();
            chk($sformatf("rr_gap_s%0d", s), {4'b0, grant}, 8'h00);
        end
        req = 4'b0000;
        tick();

        // abort on requester 2, requester 1 rises in the same cycle
        req = 4'b0100; w = 4'b0100;
        tick();
        chk("abt_grant", {4'b0, grant}, 8'h04);
        tick(); tick();
        req = 4'b0010; w = 4'b0000;
        tick();
        chk("abt_pulse", {7'b0, abort}, 8'h01);
        chk("abt_grant_off1", {4'b0, grant}, 8'h00);
        chk("abt_nomatch", {7'b0, match}, 8'h00);
        tick();
        chk("abt_pulse_off", {7'b0, abort}, 8'h00);
        chk("abt_grant_off2", {4'b0, grant}, 8'h00);
        tick();
        chk("abt_regrant", {4'b0, grant}, 8'h02);
        last = 4'b0010;
        tick();
        chk("abt_second_end", {4'b0, grant}, 8'h00);
        chk("abt_second_noabort", {7'b0, abort}, 8'h00);
        req = 4'b0000; last = 4'b0000;
        tick(); tick();

        // length cap: requester 1, w all ones, no last
        req = 4'b0010; w = 4'b1111;
        tick();
        chk("cap_grant", {4'b0, grant}, 8'h02);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("cap_grant_b%0d", k), {4'b0, grant}, (k < 8) ? 8'h02 : 8'h00);
            chk($sformatf("cap_abort_b%0d", k), {7'b0, abort}, 8'h00);
        end
        chk("cap_busy_end", {7'b0, busy}, 8'h00);
        req = 4'b0000; w = 4'b0000;
        tick();
        chk("cap_gap_abort", {7'b0, abort}, 8'h00);
        tick();

        // reset during third bit of a session on requester 2
        req = 4'b0110; w = 4'b1111;
        tick();
        chk("mrst_grant", {4'b0, grant}, 8'h04);
        tick(); tick();
        w = 4'b0000; clr = 1'b0;
        tick();
        chk("mrst_grant0", {4'b0, grant}, 8'h00);
        chk("mrst_busy0", {7'b0, busy}, 8'h00);
        chk("mrst_match0", {7'b0, match}, 8'h00);
        chk("mrst_abort0", {7'b0, abort}, 8'h00);
        chk("mrst_cnt0", match_cnt, 8'h00);
        clr = 1'b1; req = 4'b0010;
        tick();
        chk("mrst_first_grant", {4'b0, grant}, 8'h02);
        w = 4'b0010; tick();
        w = 4'b0010; tick();
        w = 4'b0000; tick();
        w = 4'b0010; last = 4'b0010; tick();
        chk("mrst_match", {7'b0, match}, 8'h01);
        chk("mrst_match_id", {6'b0, match_id}, 8'h01);
        chk("mrst_cnt", match_cnt, cnt_exp(8'd1));
        req = 4'b0000; w = 4'b0000; last = 4'b0000;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
